token_ring_ctrl: RTL and testbench

//  Parametrised next-generation router-core control FSM for the token ring.

---
 rtl/ring_pkg.sv | 41 ++++
 rtl/ring_timer.sv | 37 +++
 rtl/token_ring_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_token_ring_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// Shared encodings for the token-ring router control path: rx packet type
// codes, tx mux selections and the controller state enumeration.
package ring_pkg;

  // Packet type codes as delivered by the rx decoder.
  localparam logic [2:0] DT_TOKEN  = 3'b111;
  localparam logic [2:0] DT_ACK    = 3'b000;
  localparam logic [2:0] DT_NACK   = 3'b011;
  localparam logic [2:0] DT_DATA_C = 3'b010;
  localparam logic [2:0] DT_DATA_3 = 3'b001;

  // Transmit mux source selection.
  typedef enum logic [2:0] {
    SEL_ACK     = 3'd0,
    SEL_NACK    = 3'd1,
    SEL_FORWARD = 3'd2,
    SEL_TOKEN   = 3'd3,
    SEL_NEW     = 3'd4
  } tx_sel_e;

  // Controller states; encodings 12..15 are illegal and recover to INIT.
  typedef enum logic [3:0] {
    ST_INIT       = 4'd0,
    ST_HOLD       = 4'd1,
    ST_ENCODE     = 4'd2,
    ST_SEND_TX    = 4'd3,
    ST_WAIT_ACK   = 4'd4,
    ST_RELEASE    = 4'd5,
    ST_SEND_TOKEN = 4'd6,
    ST_LISTEN     = 4'd7,
    ST_CHECK_ADDR = 4'd8,
    ST_FORWARD    = 4'd9,
    ST_SEND_NACK  = 4'd10,
    ST_SEND_NODE  = 4'd11
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ring_timer.sv
// Loadable down-counter used for the ACK timeout and the master's lost-token
// watchdog. Saturates at zero; expired_o is high while the count is zero.
module ring_timer #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load has priority, otherwise decrement and stick at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register with synchronous reset.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/token_ring_ctrl.sv
// Token-ring router control FSM: holds/passes the token, transmits node
// packets with bounded NACK/timeout retry, and receives, forwards, ACKs or
// NACKs ring traffic. The master node regenerates a token that goes missing.
module token_ring_ctrl
  import ring_pkg::*;
#(
  parameter int ADDR_W        = 4,
  parameter int MASTER_ADDR   = 0,
  parameter int MAX_RETRY     = 3,
  parameter int ACK_TIMEOUT   = 64,
  parameter int TOKEN_TIMEOUT = 1024
) (
  input  logic              Clk_R,
  input  logic              Rst,
  input  logic [ADDR_W-1:0] r_addr,
  input  logic              rx_has_data,
  input  logic [2:0]        data_type,
  input  logic [ADDR_W-1:0] address,
  input  logic              bad_decode,
  input  logic              Packet_From_Node_Valid,
  input  logic              tx_ready,
  output logic              rc_ready,
  output logic              rc_has_data,
  output logic [2:0]        tx_data_select,
  output logic              buffer_select,
  output logic              Packet_To_Node_Valid,
  output logic              Core_Load_Ack,
  output logic              retry_fail,
  output logic              token_regen
);

  localparam int TW = $clog2(max_int(ACK_TIMEOUT, TOKEN_TIMEOUT) + 1);
  // One spare count keeps the width legal when MAX_RETRY is 0.
  localparam int RW = $clog2(MAX_RETRY + 2);

  state_e        state_q, state_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          fail_q, fail_d;
  logic          regen_q, regen_d;
  logic          do_retry;
  logic          is_master;
  logic          timer_load;
  logic          timer_en;
  logic          timer_expired;
  logic [TW-1:0] timer_val;

  assign is_master = (r_addr == ADDR_W'(MASTER_ADDR));

  // Next-state, retry bookkeeping and Moore output decode.
  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d              = state_q;
    retry_d              = retry_q;
    fail_d               = fail_q;
    regen_d              = 1'b0;
    do_retry             = 1'b0;
    rc_ready             = 1'b0;
    rc_has_data          = 1'b0;
    tx_data_select       = SEL_TOKEN;
    buffer_select        = 1'b0;
    Packet_To_Node_Valid = 1'b0;
    Core_Load_Ack        = 1'b0;
    retry_fail           = 1'b0;
    token_regen          = 1'b0;

    case (state_q)
      ST_INIT: state_d = is_master ? ST_HOLD : ST_LISTEN;

      ST_HOLD: begin
        buffer_select = 1'b1;
        token_regen   = regen_q;
        if (Packet_From_Node_Valid) begin
          state_d = ST_ENCODE;
          retry_d = '0;
          fail_d  = 1'b0;
        end else begin
          state_d = ST_SEND_TOKEN;
        end
      end

      ST_ENCODE: begin
        buffer_select  = 1'b1;
        tx_data_select = SEL_NEW;
        state_d        = ST_SEND_TX;
      end

      ST_SEND_TX: begin
        rc_has_data    = 1'b1;
        tx_data_select = SEL_NEW;
        if (tx_ready) state_d = ST_WAIT_ACK;
      end

      ST_WAIT_ACK: begin
        rc_ready = 1'b1;
        // A received packet outranks a timer expiry in the same cycle.
        if (rx_has_data) begin
          if (data_type == DT_ACK) begin
            state_d = ST_RELEASE;
            fail_d  = 1'b0;
          end else if (data_type == DT_NACK) begin
            do_retry = 1'b1;
          end
        end else if (timer_expired) begin
          do_retry = 1'b1;
        end
        if (do_retry) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            state_d = ST_SEND_TX;
            retry_d = retry_q + RW'(1);
          end else begin
            state_d = ST_RELEASE;
            fail_d  = 1'b1;
          end
        end
      end

      ST_RELEASE: begin
        Core_Load_Ack = 1'b1;
        retry_fail    = fail_q;
        state_d       = ST_HOLD;
      end

      ST_SEND_TOKEN: begin
        rc_has_data    = 1'b1;
        tx_data_select = SEL_TOKEN;
        if (tx_ready) state_d = ST_LISTEN;
      end

      ST_LISTEN: begin
        rc_ready = 1'b1;
        if (rx_has_data) begin
          state_d = ST_CHECK_ADDR;
        end else if (is_master && timer_expired) begin
          state_d = ST_HOLD;
          regen_d = 1'b1;
        end
      end

      ST_CHECK_ADDR: begin
        if (data_type == DT_TOKEN)                                state_d = ST_HOLD;
        else if ((data_type != DT_DATA_C) && (data_type != DT_DATA_3)) state_d = ST_FORWARD;
        else if (address != r_addr)                               state_d = ST_FORWARD;
        else if (bad_decode)                                      state_d = ST_SEND_NACK;
        else                                                      state_d = ST_SEND_NODE;
      end

      ST_FORWARD: begin
        rc_has_data    = 1'b1;
        tx_data_select = SEL_FORWARD;
        if (tx_ready) state_d = ST_LISTEN;
      end

      ST_SEND_NACK: begin
        rc_has_data    = 1'b1;
        tx_data_select = SEL_NACK;
        if (tx_ready) state_d = ST_LISTEN;
      end

      ST_SEND_NODE: begin
        rc_has_data          = 1'b1;
        tx_data_select       = SEL_ACK;
        Packet_To_Node_Valid = 1'b1;
        if (tx_ready) state_d = ST_LISTEN;
      end

      default: state_d = ST_INIT;
    endcase
  end

  // Timers load on entry to WAIT_ACK / LISTEN and count down while there.
  assign timer_load = (state_d != state_q) &&
                      ((state_d == ST_WAIT_ACK) || (state_d == ST_LISTEN));
  assign timer_val  = (state_d == ST_WAIT_ACK) ? TW'(ACK_TIMEOUT) : TW'(TOKEN_TIMEOUT);
  assign timer_en   = (state_q == ST_WAIT_ACK) || (state_q == ST_LISTEN);

  ring_timer #(.W(TW)) u_timer (
    .clk_i      (Clk_R),
    .rst_i      (Rst),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .en_i       (timer_en),
    .expired_o  (timer_expired)
  );

  // State and bookkeeping registers; reset abandons any packet in flight.
  always_ff @(posedge Clk_R) begin
    if (Rst) begin
      state_q <= ST_INIT;
      retry_q <= '0;
      fail_q  <= 1'b0;
      regen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      fail_q  <= fail_d;
      regen_q <= regen_d;
    end
  end

endmodule

// File: tb/tb_token_ring_ctrl.sv
// Directed bench for token_ring_ctrl: a table of address-check vectors plus
// hand-written sequences for token pass, retry, timeout and reset corners.
module tb_token_ring_ctrl;

  localparam logic [2:0] T_TOKEN = 3'b111, T_ACK = 3'b000, T_NACK = 3'b011,
                         T_DATA_C = 3'b010, T_DATA_3 = 3'b001;

  logic       Clk_R = 1'b0;
  logic       Rst = 1'b1;
  logic [3:0] r_addr = 4'd0;
  logic       rx_has_data = 1'b0;
  logic [2:0] data_type = 3'b000;
  logic [3:0] address = 4'd0;
  logic       bad_decode = 1'b0;
  logic       Packet_From_Node_Valid = 1'b0;
  logic       tx_ready = 1'b0;

  logic       rc_ready, rc_has_data, buffer_select, Packet_To_Node_Valid;
  logic       Core_Load_Ack, retry_fail, token_regen;
  logic [2:0] tx_data_select;
  logic       rc_ready_b, rc_has_data_b, buffer_select_b, Packet_To_Node_Valid_b;
  logic       Core_Load_Ack_b, retry_fail_b, token_regen_b;
  logic [2:0] tx_data_select_b;

  int checks = 0;
  int errors = 0;
  int tx_cnt = 0, tx_cnt_b = 0, ack_cnt = 0;

  always #5 Clk_R = ~Clk_R;

  token_ring_ctrl #(.ADDR_W(4), .MASTER_ADDR(0), .MAX_RETRY(3),
                    .ACK_TIMEOUT(8), .TOKEN_TIMEOUT(16)) u_dut (
    .Clk_R(Clk_R), .Rst(Rst), .r_addr(r_addr), .rx_has_data(rx_has_data),
    .data_type(data_type), .address(address), .bad_decode(bad_decode),
    .Packet_From_Node_Valid(Packet_From_Node_Valid), .tx_ready(tx_ready),
    .rc_ready(rc_ready), .rc_has_data(rc_has_data), .tx_data_select(tx_data_select),
    .buffer_select(buffer_select), .Packet_To_Node_Valid(Packet_To_Node_Valid),
    .Core_Load_Ack(Core_Load_Ack), .retry_fail(retry_fail), .token_regen(token_regen));

  token_ring_ctrl #(.ADDR_W(4), .MASTER_ADDR(0), .MAX_RETRY(1),
                    .ACK_TIMEOUT(8), .TOKEN_TIMEOUT(16)) u_dut_b (
    .Clk_R(Clk_R), .Rst(Rst), .r_addr(r_addr), .rx_has_data(rx_has_data),
    .data_type(data_type), .address(address), .bad_decode(bad_decode),
    .Packet_From_Node_Valid(Packet_From_Node_Valid), .tx_ready(tx_ready),
    .rc_ready(rc_ready_b), .rc_has_data(rc_has_data_b), .tx_data_select(tx_data_select_b),
    .buffer_select(buffer_select_b), .Packet_To_Node_Valid(Packet_To_Node_Valid_b),
    .Core_Load_Ack(Core_Load_Ack_b), .retry_fail(retry_fail_b), .token_regen(token_regen_b));

  // {rc_ready, rc_has_data, sel[2:0], buffer_select, ptnv, ack, fail, regen}
  wire [9:0] outs = {rc_ready, rc_has_data, tx_data_select, buffer_select,
                     Packet_To_Node_Valid, Core_Load_Ack, retry_fail, token_regen};
  localparam logic [9:0] RESET_OUTS = 10'b0_0_011_0_0_0_0_0;

  // Count new-packet transfers and node acks mid-cycle, away from the edge.
  always @(negedge Clk_R) begin
    if (!Rst && rc_has_data && tx_ready && tx_data_select == 3'd4) tx_cnt++;
    if (!Rst && rc_has_data_b && tx_ready && tx_data_select_b == 3'd4) tx_cnt_b++;
    if (Core_Load_Ack) ack_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk_R);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] addr, input logic pfnv, input logic rdy);
    Rst = 1'b1;
    r_addr = addr;
    rx_has_data = 1'b0;
    Packet_From_Node_Valid = pfnv;
    tx_ready = rdy;
    tick();
    tick();
    Rst = 1'b0;
  endtask

  task automatic rx_pulse(input logic [2:0] t, input logic [3:0] a, input logic b);
    data_type = t;
    address = a;
    bad_decode = b;
    rx_has_data = 1'b1;
    tick();
    rx_has_data = 1'b0;
  endtask

  // Expected outputs in the state following CHECK_ADDR:
  // {rc_has_data, sel[2:0], buffer_select, Packet_To_Node_Valid}
  typedef struct {
    logic [2:0] dtype;
    logic [3:0] addr;
    logic       bad;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int n, w, base, base_b, base_ack;

    vecs[0] = '{T_DATA_C, 4'd5, 1'b0, 6'b1_000_0_1}; // to node
    vecs[1] = '{T_DATA_3, 4'd5, 1'b0, 6'b1_000_0_1}; // to node
    vecs[2] = '{T_DATA_C, 4'd5, 1'b1, 6'b1_001_0_0}; // bad decode -> NACK
    vecs[3] = '{T_DATA_3, 4'd9, 1'b0, 6'b1_010_0_0}; // other address
    vecs[4] = '{T_DATA_C, 4'd9, 1'b1, 6'b1_010_0_0}; // address beats bad decode
    vecs[5] = '{T_ACK,    4'd5, 1'b0, 6'b1_010_0_0}; // ACK forwarded
    vecs[6] = '{T_NACK,   4'd5, 1'b0, 6'b1_010_0_0}; // NACK forwarded
    vecs[7] = '{3'b100,   4'd5, 1'b0, 6'b1_010_0_0}; // unknown code
    vecs[8] = '{T_TOKEN,  4'd5, 1'b0, 6'b0_011_1_0}; // token -> HOLD

    // Reset values and master token pass.
    Rst = 1'b1;
    tx_ready = 1'b1;
    tick();
    check("reset_outs", 32'(outs), 32'(RESET_OUTS));
    do_reset(4'd0, 1'b0, 1'b1);
    check("rst_held_outs", 32'(outs), 32'(RESET_OUTS));
    tick();
    check("master_hold", 32'(outs), 32'(10'b0_0_011_1_0_0_0_0));
    tick();
    check("master_send_token", 32'(outs), 32'(10'b0_1_011_0_0_0_0_0));
    tick();
    check("master_listen", 32'(outs), 32'(10'b1_0_011_0_0_0_0_0));

    // Lost token: 17 LISTEN cycles (timer 16 down to 0), then regen.
    n = 0;
    while (rc_ready && n < 40) begin
      n++;
      tick();
    end
    check("regen_listen_cycles", 32'(n), 32'd17);
    check("regen_pulse_hold", 32'({token_regen, buffer_select}), 32'b11);
    tick();
    check("regen_one_cycle", 32'({token_regen, rc_has_data, tx_data_select}), 32'b0_1_011);

    // Node packet, 3 NACKs then ACK on MAX_RETRY=3.
    do_reset(4'd0, 1'b1, 1'b1);
    base = tx_cnt;
    tick();
    tick();
    Packet_From_Node_Valid = 1'b0;
    check("encode", 32'({buffer_select, rc_has_data, tx_data_select}), 32'b1_0_100);
    tick();
    check("send_tx", 32'({rc_has_data, tx_data_select}), 32'b1_100);
    tick();
    check("wait_ack", 32'(rc_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      rx_pulse(T_NACK, 4'd0, 1'b0);
      tick();
    end
    rx_pulse(T_ACK, 4'd0, 1'b0);
    check("nack_release", 32'({Core_Load_Ack, retry_fail}), 32'b10);
    check("nack_tx_count", 32'(tx_cnt - base), 32'd4);

    // ACK arriving on the exact cycle the ACK timer hits zero wins.
    Packet_From_Node_Valid = 1'b1;
    tick();
    tick();
    Packet_From_Node_Valid = 1'b0;
    base = tx_cnt;
    tick();
    tick();
    repeat (8) tick();
    check("timer_zero_still_wait", 32'(rc_ready), 32'd1);
    rx_pulse(T_ACK, 4'd0, 1'b0);
    check("rx_beats_timeout", 32'({Core_Load_Ack, retry_fail}), 32'b10);
    check("rx_beats_tx_count", 32'(tx_cnt - base), 32'd1);

    // Silent ring on MAX_RETRY=1, ACK_TIMEOUT=8: two transmits, then drop.
    do_reset(4'd0, 1'b1, 1'b1);
    base_b = tx_cnt_b;
    tick();
    tick();
    Packet_From_Node_Valid = 1'b0;
    n = 0;
    w = 0;
    while (!Core_Load_Ack_b && n < 100) begin
      tick();
      n++;
      if (rc_ready_b) w++;
    end
    check("timeout_release", 32'({Core_Load_Ack_b, retry_fail_b}), 32'b11);
    check("timeout_wait_cycles", 32'(w), 32'd18);
    check("timeout_tx_count", 32'(tx_cnt_b - base_b), 32'd2);
    tick();
    check("timeout_ack_pulse", 32'({Core_Load_Ack_b, retry_fail_b}), 32'b00);

    // Reset while stalled in SEND_TX: packet abandoned, no node ack.
    do_reset(4'd0, 1'b1, 1'b0);
    tick();
    tick();
    Packet_From_Node_Valid = 1'b0;
    tick();
    tick();
    check("stalled_send_tx", 32'({rc_has_data, tx_data_select}), 32'b1_100);
    base_ack = ack_cnt;
    Rst = 1'b1;
    tick();
    check("mid_tx_reset_outs", 32'(outs), 32'(RESET_OUTS));
    Rst = 1'b0;
    tx_ready = 1'b1;
    tick();
    tick();
    check("after_reset_token", 32'({rc_has_data, tx_data_select}), 32'b1_011);
    check("no_ack_on_abandon", 32'(ack_cnt - base_ack), 32'd0);

    // Non-master: address-check decode table.
    do_reset(4'd5, 1'b0, 1'b1);
    tick();
    check("nonmaster_listen", 32'(outs), 32'(10'b1_0_011_0_0_0_0_0));
    for (int i = 0; i < 9; i++) begin
      rx_pulse(vecs[i].dtype, vecs[i].addr, vecs[i].bad);
      tick();
      check($sformatf("vec%0d_outs", i),
            32'({rc_has_data, tx_data_select, buffer_select, Packet_To_Node_Valid}),
            32'(vecs[i].exp));
      n = 0;
      while (!rc_ready && n < 10) begin
        tick();
        n++;
      end
      check($sformatf("vec%0d_back_listen", i), 32'(rc_ready), 32'd1);
    end

    // Forward with tx_ready low for 5 cycles: request held 6 cycles.
    tx_ready = 1'b0;
    rx_pulse(T_DATA_C, 4'd9, 1'b0);
    tick();
    n = 0;
    w = 0;
    while (rc_has_data && n < 20) begin
      n++;
      if (tx_data_select == 3'd2) w++;
      if (n == 6) tx_ready = 1'b1;
      tick();
    end
    check("forward_hold_cycles", 32'(n), 32'd6);
    check("forward_sel_cycles", 32'(w), 32'd6);
    check("forward_back_listen", 32'(rc_ready), 32'd1);

    // Non-master never regenerates the token.
    n = 0;
    repeat (30) begin
      tick();
      if (!rc_ready || token_regen) n++;
    end
    check("nonmaster_no_regen", 32'(n), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
